// File: rtl/serial_tc_adder.sv
// Bit-serial two's-complement adder: adds LSB-first over bitNumber cycles, then
// presents the wrapped sum, its sign-magnitude form, and overflow/range flags.
module serial_tc_adder #(
    parameter int bitNumber = 8
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 start,
    input  logic [bitNumber-1:0] A_tc,
    input  logic [bitNumber-1:0] B_tc,
    output logic                 busy,
    output logic                 done,
    output logic [bitNumber-1:0] sum_tc,
    output logic [bitNumber-1:0] sum_sm,
    output logic                 ovf,
    output logic                 sm_err
);
    localparam int W  = bitNumber;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIX, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_c;
    logic            r_ovf;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic [W:0]      w_sm;

    logic w_a, w_b, w_s, w_c;

    // Returns {sm_err, sign-magnitude value}; an overflowed sum yields zero.
    function automatic logic [W:0] tc_to_sm(input logic [W-1:0] v, input logic of);
        logic [W-1:0] neg;
        neg = ~v + W'(1);
        if (of)
            return '0;
        else if (v == {1'b1, {(W-1){1'b0}}})
            return {1'b1, {W{1'b1}}};
        else if (!v[W-1])
            return {1'b0, v};
        else
            return {1'b0, 1'b1, neg[W-2:0]};
    endfunction

    assign w_a  = r_a[0];
    assign w_b  = r_b[0];
    assign w_s  = w_a ^ w_b ^ r_c;
    assign w_c  = (w_a & w_b) | (r_c & (w_a ^ w_b));
    assign w_sm = tc_to_sm(r_res, r_ovf);

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_tc  <= '0;
            sum_sm  <= '0;
            ovf     <= 1'b0;
            sm_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A_tc;
                        r_b     <= B_tc;
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= {w_s, r_res[W-1:1]};
                    r_c   <= w_c;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W-1)) begin
                        // On the MSB, r_c is the carry in and w_c the carry out.
                        r_ovf   <= r_c ^ w_c;
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    sum_tc  <= r_res;
                    sum_sm  <= w_sm[W-1:0];
                    sm_err  <= w_sm[W];
                    ovf     <= r_ovf;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tc_adder.sv
// Directed bench for serial_tc_adder (bitNumber=8): hand-computed sums, latency,
// ignored restart and mid-add reset.
module tb_serial_tc_adder;
    logic       clk1 = 1'b0;
    logic       rst, start;
    logic [7:0] A_tc, B_tc;
    logic       busy, done, ovf, sm_err;
    logic [7:0] sum_tc, sum_sm;

    int total = 0;
    int bad   = 0;

    serial_tc_adder #(.bitNumber(8)) dut (
        .clk1(clk1), .rst(rst), .start(start), .A_tc(A_tc), .B_tc(B_tc),
        .busy(busy), .done(done), .sum_tc(sum_tc), .sum_sm(sum_sm),
        .ovf(ovf), .sm_err(sm_err)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] etc, input logic [7:0] esm,
                            input logic eovf, input logic eerr);
        chk({tag, ".sum_tc"}, 32'(sum_tc), 32'(etc));
        chk({tag, ".sum_sm"}, 32'(sum_sm), 32'(esm));
        chk({tag, ".ovf"},    32'(ovf),    32'(eovf));
        chk({tag, ".sm_err"}, 32'(sm_err), 32'(eerr));
    endtask

    // Starts an add at the next edge, checks busy/latency, then the results at done.
    task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] etc, input logic [7:0] esm,
                           input logic eovf, input logic eerr);
        int n;
        @(negedge clk1);
        A_tc = a; B_tc = b; start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        A_tc = ~a; B_tc = ~b;
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        chk({tag, ".done_lo"}, 32'(done), 32'd0);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk1); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd10);
        chk({tag, ".busy_off"}, 32'(busy), 32'd0);
        chk_outs(tag, etc, esm, eovf, eerr);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; A_tc = '0; B_tc = '0;
        repeat (2) @(posedge clk1);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk_outs("rst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk1);
        rst = 1'b0;

        run_add("p5p3",   8'h05, 8'h03, 8'h08, 8'h08, 1'b0, 1'b0);
        run_add("m5p3",   8'hFB, 8'h03, 8'hFE, 8'h82, 1'b0, 1'b0);
        run_add("100p100",8'h64, 8'h64, 8'hC8, 8'h00, 1'b1, 1'b0);
        run_add("m1p1",   8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        run_add("127p1",  8'h7F, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0);
        run_add("m127p0", 8'h81, 8'h00, 8'h81, 8'hFF, 1'b0, 1'b0);
        run_add("m128m128",8'h80,8'h80, 8'h00, 8'h00, 1'b1, 1'b0);
        run_add("m64m64", 8'hC0, 8'hC0, 8'h80, 8'hFF, 1'b0, 1'b1);

        // Restart attempt three cycles into ADD with different operands.
        @(negedge clk1);
        A_tc = 8'h05; B_tc = 8'h03; start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        A_tc = 8'h70; B_tc = 8'h70; start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk1); #1;
            if (done === 1'b1) ndone++;
        end
        chk("restart.ndone", 32'(ndone), 32'd1);
        chk_outs("restart", 8'h08, 8'h08, 1'b0, 1'b0);

        run_add("pre_rst", 8'hC0, 8'hC0, 8'h80, 8'hFF, 1'b0, 1'b1);

        // Reset on the fourth ADD edge aborts the add.
        @(negedge clk1);
        A_tc = 8'h64; B_tc = 8'h64; start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        rst = 1'b1;
        @(posedge clk1); #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk_outs("abort", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk1);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk1); #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort.ndone", 32'(ndone), 32'd0);
        chk("abort.idle_busy", 32'(busy), 32'd0);

        run_add("post_rst", 8'hFB, 8'h03, 8'hFE, 8'h82, 1'b0, 1'b0);

        repeat (3) @(posedge clk1);
        #1;
        chk_outs("hold", 8'hFE, 8'h82, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
